// File: rtl/blitter_pkg.sv
// Shared widths, state type and helpers for the blitter memory writer.
package blitter_pkg;

  localparam int BLIT_ADDR_WIDTH = 26;
  localparam int BLIT_BE_WIDTH   = 4;
  localparam int BLIT_DATA_WIDTH = 32;

  localparam logic [BLIT_BE_WIDTH-1:0] BLIT_BE_FULL = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    ISSUE = 2'd2
  } blit_state_e;

  function automatic logic be_is_full(input logic [BLIT_BE_WIDTH-1:0] be);
    return be == BLIT_BE_FULL;
  endfunction

endpackage

// File: rtl/blitter_mem_writer_if.sv
// FIFO read side, flush/idle control and memory arbiter write port of the blitter writer.
interface blitter_mem_writer_if
  import blitter_pkg::*;
#(
  parameter int ADDR_WIDTH = BLIT_ADDR_WIDTH
) ();

  logic [ADDR_WIDTH-1:0]      fifo_address;
  logic [BLIT_BE_WIDTH-1:0]   fifo_byte_en;
  logic [BLIT_DATA_WIDTH-1:0] fifo_data;
  logic                       fifo_valid;
  logic                       fifo_ready;
  logic                       flush;
  logic                       mem_request;
  logic [ADDR_WIDTH-1:0]      mem_address;
  logic [BLIT_BE_WIDTH-1:0]   mem_byte_en;
  logic [BLIT_DATA_WIDTH-1:0] mem_wdata;
  logic                       mem_ack;
  logic                       idle;

  // The writer itself
  modport slave (
    input  fifo_address, fifo_byte_en, fifo_data, fifo_valid, flush, mem_ack,
    output fifo_ready, mem_request, mem_address, mem_byte_en, mem_wdata, idle
  );

  // FIFO, blitter control and arbiter side
  modport master (
    output fifo_address, fifo_byte_en, fifo_data, fifo_valid, flush, mem_ack,
    input  fifo_ready, mem_request, mem_address, mem_byte_en, mem_wdata, idle
  );

endinterface

// File: rtl/blitter_byte_merge.sv
// Per-lane merge of an incoming partial write into the held word.
module blitter_byte_merge
  import blitter_pkg::*;
(
  input  logic [BLIT_DATA_WIDTH-1:0] i_old_data,
  input  logic [BLIT_BE_WIDTH-1:0]   i_old_be,
  input  logic [BLIT_DATA_WIDTH-1:0] i_new_data,
  input  logic [BLIT_BE_WIDTH-1:0]   i_new_be,
  output logic [BLIT_DATA_WIDTH-1:0] o_data,
  output logic [BLIT_BE_WIDTH-1:0]   o_be
);

  always_comb begin
    o_data = i_old_data;
    for (int i = 0; i < BLIT_BE_WIDTH; i++) begin
      if (i_new_be[i]) begin
        o_data[i*8 +: 8] = i_new_data[i*8 +: 8];
      end
    end
    o_be = i_old_be | i_new_be;
  end

endmodule

// File: rtl/blitter_mem_writer.sv
// Drains the blitter write FIFO into word writes, coalescing partial writes to the same word.
//
// state | meaning
// EMPTY | nothing held; head entry is popped and becomes the held word
// HOLD  | partial word held; merging same-address entries, timing out on an empty FIFO
// ISSUE | held word presented to the arbiter until mem_ack
module blitter_mem_writer
  import blitter_pkg::*;
#(
  parameter int ADDR_WIDTH = BLIT_ADDR_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input logic                 clock,
  input logic                 reset,
  blitter_mem_writer_if.slave bus
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  blit_state_e                r_state;
  blit_state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_hold_addr;
  logic [ADDR_WIDTH-1:0]      w_hold_addr_nxt;
  logic [BLIT_BE_WIDTH-1:0]   r_hold_be;
  logic [BLIT_BE_WIDTH-1:0]   w_hold_be_nxt;
  logic [BLIT_DATA_WIDTH-1:0] r_hold_data;
  logic [BLIT_DATA_WIDTH-1:0] w_hold_data_nxt;
  logic [7:0]                 r_timer;
  logic [7:0]                 w_timer_nxt;
  logic                       r_mem_request;
  logic                       w_fifo_ready;
  logic                       w_addr_match;
  logic [BLIT_DATA_WIDTH-1:0] w_merge_data;
  logic [BLIT_BE_WIDTH-1:0]   w_merge_be;

  assign w_addr_match = (bus.fifo_address == r_hold_addr);

  blitter_byte_merge u_merge (
    .i_old_data (r_hold_data),
    .i_old_be   (r_hold_be),
    .i_new_data (bus.fifo_data),
    .i_new_be   (bus.fifo_byte_en),
    .o_data     (w_merge_data),
    .o_be       (w_merge_be)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_addr_nxt = r_hold_addr;
    w_hold_be_nxt   = r_hold_be;
    w_hold_data_nxt = r_hold_data;
    w_timer_nxt     = r_timer;
    w_fifo_ready    = 1'b0;
    case (r_state)
      EMPTY: begin
        w_fifo_ready = 1'b1;
        if (bus.fifo_valid) begin
          w_hold_addr_nxt = bus.fifo_address;
          w_hold_be_nxt   = bus.fifo_byte_en;
          w_hold_data_nxt = bus.fifo_data;
          w_timer_nxt     = 8'd0;
          w_state_nxt     = be_is_full(bus.fifo_byte_en) ? ISSUE : HOLD;
        end
      end
      HOLD: begin
        if (bus.fifo_valid && w_addr_match) begin
          // Merge wins over flush; a flush still sends the merged word this cycle
          w_fifo_ready    = 1'b1;
          w_hold_be_nxt   = w_merge_be;
          w_hold_data_nxt = w_merge_data;
          w_timer_nxt     = 8'd0;
          if (be_is_full(w_merge_be) || bus.flush) begin
            w_state_nxt = ISSUE;
          end
        end else if (bus.fifo_valid) begin
          // Different word waiting: write ours first so memory sees FIFO order
          w_state_nxt = ISSUE;
        end else if ((r_timer == TIMER_LAST) || bus.flush) begin
          w_state_nxt = ISSUE;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      ISSUE: begin
        if (bus.mem_ack && r_mem_request) begin
          w_hold_be_nxt = '0;
          w_state_nxt   = EMPTY;
        end
      end
      default: begin
        w_state_nxt   = EMPTY;
        w_hold_be_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= EMPTY;
      r_hold_addr   <= '0;
      r_hold_be     <= '0;
      r_hold_data   <= '0;
      r_timer       <= 8'd0;
      r_mem_request <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_addr   <= w_hold_addr_nxt;
      r_hold_be     <= w_hold_be_nxt;
      r_hold_data   <= w_hold_data_nxt;
      r_timer       <= w_timer_nxt;
      r_mem_request <= (w_state_nxt == ISSUE);
    end
  end

  assign bus.fifo_ready  = w_fifo_ready;
  assign bus.mem_request = r_mem_request;
  assign bus.mem_address = r_hold_addr;
  assign bus.mem_byte_en = r_hold_be;
  assign bus.mem_wdata   = r_hold_data;
  assign bus.idle        = (r_state == EMPTY) && !bus.fifo_valid;

endmodule

// File: tb/tb_blitter_mem_writer.sv
// Bench for blitter_mem_writer: directed latency/ordering cases plus a random stream
// checked against a byte-level memory reference and a pops-since-last-write model.
module tb_blitter_mem_writer;

  localparam int AW     = 26;
  localparam int TMO    = 16;
  localparam int N_RAND = 1000;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  blitter_mem_writer_if #(.ADDR_WIDTH(AW)) bus ();

  blitter_mem_writer #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] ref_mem [int];
  logic [7:0] dut_mem [int];

  logic [AW-1:0] e_addr [N_RAND];
  logic [3:0]    e_be   [N_RAND];
  logic [31:0]   e_data [N_RAND];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.fifo_address = a;
    bus.fifo_byte_en = be;
    bus.fifo_data    = d;
    bus.fifo_valid   = 1'b1;
  endtask

  // Ack is raised for one full cycle so the compare process sees the accepting edge
  task automatic do_ack();
    tick();
    bus.mem_ack = 1'b1;
    @(negedge clock);
    tick();
    bus.mem_ack = 1'b0;
  endtask

  task automatic chk_word(input string name, input logic [AW-1:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    chk({name, "_req"},  bus.mem_request, 1'b1);
    chk({name, "_addr"}, bus.mem_address, a);
    chk({name, "_be"},   bus.mem_byte_en, be);
    chk({name, "_data"}, bus.mem_wdata, d);
  endtask

  // Every write must carry exactly the bytes popped since the previous write, all for one word
  initial begin : compare
    logic          pend_v;
    logic [AW-1:0] pend_addr;
    logic [3:0]    pend_be;
    logic [31:0]   pend_data;
    logic          prev_req, prev_ack;
    logic [AW-1:0] prev_addr;
    logic [3:0]    prev_be;
    logic [31:0]   prev_data;
    pend_v = 0; pend_addr = '0; pend_be = '0; pend_data = '0;
    prev_req = 0; prev_ack = 0; prev_addr = '0; prev_be = '0; prev_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend_v = 0; pend_be = '0; prev_req = 0; prev_ack = 0;
      end else if (cmp_en) begin
        chk("idle_rule", bus.idle, !bus.fifo_valid && !bus.mem_request && !pend_v);
        if (bus.mem_request) chk("ready_while_req", bus.fifo_ready, 1'b0);
        else if (!pend_v)    chk("ready_when_empty", bus.fifo_ready, 1'b1);
        if (prev_req && !prev_ack) begin
          chk("req_held", bus.mem_request, 1'b1);
          chk("addr_stable", bus.mem_address, prev_addr);
          chk("be_stable", bus.mem_byte_en, prev_be);
          chk("data_stable", bus.mem_wdata, prev_data);
        end
        if (bus.mem_request && bus.mem_ack) begin
          chk("wr_has_pops", pend_v, 1'b1);
          chk("wr_addr", bus.mem_address, pend_addr);
          chk("wr_be", bus.mem_byte_en, pend_be);
          for (int i = 0; i < 4; i++) begin
            if (pend_be[i]) chk("wr_lane", bus.mem_wdata[i*8 +: 8], pend_data[i*8 +: 8]);
            if (bus.mem_byte_en[i]) dut_mem[int'(bus.mem_address)*4 + i] = bus.mem_wdata[i*8 +: 8];
          end
          pend_v = 0;
          pend_be = '0;
        end
        if (bus.fifo_valid && bus.fifo_ready) begin
          if (pend_v) chk("pop_same_word", bus.fifo_address, pend_addr);
          else pend_addr = bus.fifo_address;
          pend_v = 1;
          for (int i = 0; i < 4; i++)
            if (bus.fifo_byte_en[i]) pend_data[i*8 +: 8] = bus.fifo_data[i*8 +: 8];
          pend_be = pend_be | bus.fifo_byte_en;
        end
        prev_req  = bus.mem_request;
        prev_ack  = bus.mem_ack;
        prev_addr = bus.mem_address;
        prev_be   = bus.mem_byte_en;
        prev_data = bus.mem_wdata;
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  n;
    int  idx;
    int  cyc;
    bit  done;
    bit  popped;
    logic [8:0] got;

    reset = 1'b1;
    bus.fifo_valid = 0; bus.fifo_address = '0; bus.fifo_byte_en = '0; bus.fifo_data = '0;
    bus.flush = 0; bus.mem_ack = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req", bus.mem_request, 1'b0);
    chk("rst_addr", bus.mem_address, '0);
    chk("rst_wdata", bus.mem_wdata, '0);
    chk("rst_be", bus.mem_byte_en, '0);
    chk("rst_ready", bus.fifo_ready, 1'b1);
    chk("rst_idle", bus.idle, 1'b1);
    #1 bus.fifo_valid = 1'b1;
    #1 chk("rst_idle_follows_valid", bus.idle, 1'b0);
    bus.fifo_valid = 1'b0;
    tick();
    reset = 1'b0;
    cmp_en = 1'b1;

    // Full word: request the very next cycle
    tick(); offer(26'h100, 4'hF, 32'hAABBCCDD);
    @(negedge clock); chk("full_ready", bus.fifo_ready, 1'b1);
    tick(); bus.fifo_valid = 0;
    @(negedge clock); chk_word("full", 26'h100, 4'hF, 32'hAABBCCDD);
    tick();
    @(negedge clock); chk_word("full_hold", 26'h100, 4'hF, 32'hAABBCCDD);
    do_ack();
    @(negedge clock);
    chk("full_done_req", bus.mem_request, 1'b0);
    chk("full_done_idle", bus.idle, 1'b1);

    // Four byte lanes to one word coalesce without waiting for the timer
    for (int k = 0; k < 4; k++) begin
      tick(); offer(26'h200, 4'(1 << k), 32'((k + 1) * 8'h11) << (8 * k));
      @(negedge clock); chk("coal_ready", bus.fifo_ready, 1'b1);
    end
    tick(); bus.fifo_valid = 0;
    @(negedge clock); chk_word("coal", 26'h200, 4'hF, 32'h44332211);
    do_ack();
    @(negedge clock); chk("coal_done", bus.mem_request, 1'b0);

    // Different address waits in the FIFO until the held word is written
    tick(); offer(26'h300, 4'h3, 32'h0000BEEF);
    @(negedge clock);
    tick(); offer(26'h301, 4'h1, 32'h0000005A);
    @(negedge clock);
    chk("diff_ready", bus.fifo_ready, 1'b0);
    chk("diff_noreq", bus.mem_request, 1'b0);
    tick();
    @(negedge clock);
    chk_word("diff", 26'h300, 4'h3, 32'h0000BEEF);
    chk("diff_ready_issue", bus.fifo_ready, 1'b0);
    do_ack();
    @(negedge clock);
    chk("diff_pop_after_ack", bus.fifo_ready, 1'b1);
    tick(); bus.fifo_valid = 0;
    @(negedge clock);
    chk("diff_held", bus.mem_request, 1'b0);
    chk("diff_held_idle", bus.idle, 1'b0);
    tick(); bus.flush = 1;
    @(negedge clock);
    tick(); bus.flush = 0;
    @(negedge clock); chk_word("diff2", 26'h301, 4'h1, 32'h0000005A);
    do_ack();
    @(negedge clock);

    // Lone partial word: released TIMEOUT+1 cycles after the pop
    tick(); offer(26'h400, 4'h4, 32'h00CC0000);
    @(negedge clock);
    tick(); bus.fifo_valid = 0;
    n = 1;
    @(negedge clock);
    while (!bus.mem_request && n < 40) begin
      tick(); n++;
      @(negedge clock);
    end
    chk("timeout_latency", n, 17);
    chk_word("timeout", 26'h400, 4'h4, 32'h00CC0000);
    do_ack();
    @(negedge clock);

    // Same word, flush raised in cycle 3
    tick(); offer(26'h400, 4'h4, 32'h00CC0000);
    @(negedge clock);
    tick(); bus.fifo_valid = 0;
    @(negedge clock);
    tick();
    @(negedge clock); chk("flush_c2", bus.mem_request, 1'b0);
    tick(); bus.flush = 1;
    @(negedge clock); chk("flush_c3", bus.mem_request, 1'b0);
    tick(); bus.flush = 0;
    @(negedge clock); chk("flush_c4", bus.mem_request, 1'b1);
    do_ack();
    @(negedge clock);

    // Withheld ack, then asynchronous reset mid-request
    tick(); offer(26'h500, 4'hF, 32'h12345678);
    @(negedge clock);
    tick(); bus.fifo_valid = 0;
    @(negedge clock); chk("stall_req", bus.mem_request, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clock);
      chk_word("stall", 26'h500, 4'hF, 32'h12345678);
      chk("stall_ready", bus.fifo_ready, 1'b0);
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", bus.mem_request, 1'b0);
    chk("async_rst_ready", bus.fifo_ready, 1'b1);
    chk("async_rst_addr", bus.mem_address, '0);
    chk("async_rst_idle", bus.idle, 1'b1);
    tick(); tick();
    reset = 1'b0;
    @(negedge clock); chk("post_rst_req", bus.mem_request, 1'b0);

    // Random stream with stalls on ack and occasional flush
    dut_mem.delete();
    ref_mem.delete();
    for (int i = 0; i < N_RAND; i++) begin
      e_addr[i] = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'(26'h40 + $urandom_range(0, 2));
      e_be[i]   = 4'($urandom_range(1, 15));
      e_data[i] = $urandom;
      for (int l = 0; l < 4; l++)
        if (e_be[i][l]) ref_mem[int'(e_addr[i])*4 + l] = e_data[i][l*8 +: 8];
    end
    idx = 0; cyc = 0; done = 0;
    tick();
    while (!done && cyc < 60000) begin
      @(negedge clock);
      popped = bus.fifo_valid && bus.fifo_ready;
      if (popped) idx++;
      done = (idx == N_RAND) && !popped && bus.idle;
      tick();
      cyc++;
      if (idx < N_RAND) begin
        if (!bus.fifo_valid || popped) bus.fifo_valid = ($urandom_range(0, 3) != 0);
        bus.fifo_address = e_addr[idx];
        bus.fifo_byte_en = e_be[idx];
        bus.fifo_data    = e_data[idx];
      end else begin
        bus.fifo_valid = 0;
      end
      bus.mem_ack = ($urandom_range(0, 2) == 0);
      bus.flush   = ($urandom_range(0, 40) == 0);
    end
    bus.mem_ack = 0; bus.flush = 0; bus.fifo_valid = 0;
    chk("random_drained", done, 1'b1);
    chk("mem_size", dut_mem.num(), ref_mem.num());
    foreach (ref_mem[k]) begin
      got = dut_mem.exists(k) ? {1'b0, dut_mem[k]} : 9'h1FF;
      chk("mem_byte", got, {1'b0, ref_mem[k]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
